// File: rtl/connect_pkg.sv
// -----------------------------------------------------------------------------
// connect_pkg
// Shared definitions for the AIDC/XHB channel connect switch:
//   - request channel indices inside the packed 3-channel request buses
//   - state encoding of the mode-switch drain FSM
// -----------------------------------------------------------------------------
package connect_pkg;

    localparam int CH_AR = 0;
    localparam int CH_AW = 1;
    localparam int CH_W  = 2;
    localparam int NREQ  = 3;

    typedef enum logic [1:0] {
        BYP   = 2'd0,
        DRN_C = 2'd1,
        CMP   = 2'd2,
        DRN_B = 2'd3
    } sw_state_t;

endpackage

// File: rtl/connect_skid.sv
// -----------------------------------------------------------------------------
// connect_skid
// Two-entry valid/ready skid buffer. in_ready and out_valid both come
// straight from the occupancy register, so neither side sees a combinational
// path through the buffer. Full throughput with one cycle of latency.
// Ports:
//   clk, rst_n (async, active-low), srst (sync clear)
//   in_valid / in_ready / in_data    upstream side
//   out_valid / out_ready / out_data downstream side
// -----------------------------------------------------------------------------
module connect_skid #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          srst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic [DW-1:0] mem_r [2];
    logic          wr_ptr_r;
    logic          rd_ptr_r;
    logic [1:0]    cnt_r;
    logic          push_s;
    logic          pop_s;

    assign in_ready  = (cnt_r != 2'd2);
    assign out_valid = (cnt_r != 2'd0);
    assign out_data  = mem_r[rd_ptr_r];
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;

    // Payload storage; contents are don't-care while the entry is empty
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            cnt_r    <= 2'd0;
        end else if (srst) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            cnt_r    <= 2'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + 2'd1;
                2'b01:   cnt_r <= cnt_r - 2'd1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/connect_switch.sv
// -----------------------------------------------------------------------------
// connect_switch
// Steers CNN-engine AR/AW/W requests straight to XHB (bypass) or through AIDC
// (compress), and steers the XHB R channel the matching way. A mode change
// first drains: new requests are blocked until every outstanding read burst
// (counted to the last R beat) and write burst (counted to B) has completed,
// then the path flips. B always passes through and is counted.
//
// Optional build macro CONNECT_OREG_EN: adds a 2-entry skid buffer on every
// MREQ channel and on RO (1 cycle latency, registered READY); the drain then
// also waits for those buffers to empty.
//
// Ports:
//   CLK_i, RSTN_i (async, active-low)
//   ENABLE_REQ_i requested mode (1 = compress); ENABLE_o effective mode
//   BUSY_o drain in progress; ERR_o sticky outstanding-counter underflow
//   REQ_*   engine requests (AR=0, AW=1, W=2, channel c at [c*DW +: DW])
//   EREQ_*  requests to AIDC;  CREQ_* compressed requests from AIDC
//   MREQ_*  requests to XHB
//   R_* R from XHB, ER_* R to AIDC, CR_* R from AIDC, RO_* R to engine
//   B_* B from XHB, BO_* B to engine
// -----------------------------------------------------------------------------
module connect_switch
    import connect_pkg::*;
#(
    parameter int DW         = 32,
    parameter int MAX_OUTSTD = 16,
    parameter int RLAST_BIT  = 0
) (
    input  logic               CLK_i,
    input  logic               RSTN_i,
    input  logic               ENABLE_REQ_i,
    output logic               ENABLE_o,
    output logic               BUSY_o,
    output logic               ERR_o,
    input  logic [NREQ-1:0]    REQ_VALID_i,
    output logic [NREQ-1:0]    REQ_READY_o,
    input  logic [NREQ*DW-1:0] REQ_i,
    output logic [NREQ-1:0]    EREQ_VALID_o,
    input  logic [NREQ-1:0]    EREQ_READY_i,
    output logic [NREQ*DW-1:0] EREQ_o,
    input  logic [NREQ-1:0]    CREQ_VALID_i,
    output logic [NREQ-1:0]    CREQ_READY_o,
    input  logic [NREQ*DW-1:0] CREQ_i,
    output logic [NREQ-1:0]    MREQ_VALID_o,
    input  logic [NREQ-1:0]    MREQ_READY_i,
    output logic [NREQ*DW-1:0] MREQ_o,
    input  logic               R_VALID_i,
    output logic               R_READY_o,
    input  logic [DW-1:0]      R_i,
    output logic               ER_VALID_o,
    input  logic               ER_READY_i,
    output logic [DW-1:0]      ER_o,
    input  logic               CR_VALID_i,
    output logic               CR_READY_o,
    input  logic [DW-1:0]      CR_i,
    output logic               RO_VALID_o,
    input  logic               RO_READY_i,
    output logic [DW-1:0]      RO_o,
    input  logic               B_VALID_i,
    output logic               B_READY_o,
    input  logic [DW-1:0]      B_i,
    output logic               BO_VALID_o,
    input  logic               BO_READY_i,
    output logic [DW-1:0]      BO_o
);

    localparam int            CW      = $clog2(MAX_OUTSTD + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTD);

    // Saturating up/down step; a decrement at zero holds at zero
    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cnt,
                                               input logic inc, input logic dec);
        logic [CW-1:0] nxt;
        case ({inc, dec})
            2'b10:   nxt = cnt + CW'(1);
            2'b01:   nxt = (cnt == {CW{1'b0}}) ? cnt : cnt - CW'(1);
            default: nxt = cnt;
        endcase
        return nxt;
    endfunction

    sw_state_t          state_r;
    logic               enable_r;
    logic               busy_r;
    logic               err_r;
    logic [CW-1:0]      rd_cnt_r;
    logic [CW-1:0]      wr_cnt_r;

    logic               steady_s;
    logic [NREQ-1:0]    fwd_mask_s;
    logic [NREQ-1:0]    mreq_valid_s;
    logic [NREQ-1:0]    mreq_ready_s;
    logic [NREQ*DW-1:0] mreq_data_s;
    logic               ro_valid_s;
    logic               ro_ready_s;
    logic [DW-1:0]      ro_data_s;
    logic               skid_busy_s;
    logic               drain_idle_s;
    logic               rd_inc_s, rd_dec_s, wr_inc_s, wr_dec_s;
    logic               underflow_s;

    assign ENABLE_o = enable_r;
    assign BUSY_o   = busy_r;
    assign ERR_o    = err_r;

    assign EREQ_o     = REQ_i;
    assign ER_o       = R_i;
    assign BO_VALID_o = B_VALID_i;
    assign BO_o       = B_i;
    assign B_READY_o  = BO_READY_i;

    assign steady_s = (state_r == BYP) || (state_r == CMP);

    // Per-channel admission: blocked while draining, AR/AW blocked at the cap.
    // Applied to both valid and ready so no beat is forwarded without being taken.
    always_comb begin
        fwd_mask_s = {NREQ{1'b0}};
        if (steady_s) begin
            fwd_mask_s[CH_AR] = (rd_cnt_r != CNT_MAX);
            fwd_mask_s[CH_AW] = (wr_cnt_r != CNT_MAX);
            fwd_mask_s[CH_W]  = 1'b1;
        end else begin
            fwd_mask_s = {NREQ{1'b0}};
        end
    end

    // Request steering; CREQ keeps flowing to XHB during a drain out of compress
    always_comb begin
        mreq_valid_s = {NREQ{1'b0}};
        mreq_data_s  = REQ_i;
        EREQ_VALID_o = {NREQ{1'b0}};
        REQ_READY_o  = {NREQ{1'b0}};
        CREQ_READY_o = {NREQ{1'b0}};
        if (enable_r) begin
            EREQ_VALID_o = REQ_VALID_i & fwd_mask_s;
            REQ_READY_o  = EREQ_READY_i & fwd_mask_s;
            mreq_valid_s = CREQ_VALID_i;
            mreq_data_s  = CREQ_i;
            CREQ_READY_o = mreq_ready_s;
        end else begin
            mreq_valid_s = REQ_VALID_i & fwd_mask_s;
            REQ_READY_o  = mreq_ready_s & fwd_mask_s;
        end
    end

    // R steering follows the effective mode, including during a drain
    always_comb begin
        ro_valid_s = R_VALID_i;
        ro_data_s  = R_i;
        R_READY_o  = ro_ready_s;
        ER_VALID_o = 1'b0;
        CR_READY_o = 1'b0;
        if (enable_r) begin
            ER_VALID_o = R_VALID_i;
            R_READY_o  = ER_READY_i;
            ro_valid_s = CR_VALID_i;
            ro_data_s  = CR_i;
            CR_READY_o = ro_ready_s;
        end else begin
            ro_valid_s = R_VALID_i;
            ro_data_s  = R_i;
            R_READY_o  = ro_ready_s;
        end
    end

`ifdef CONNECT_OREG_EN
    for (genvar c = 0; c < NREQ; c++) begin : g_mreq_skid
        connect_skid #(.DW(DW)) u_skid (
            .clk       (CLK_i),
            .rst_n     (RSTN_i),
            .srst      (1'b0),
            .in_valid  (mreq_valid_s[c]),
            .in_ready  (mreq_ready_s[c]),
            .in_data   (mreq_data_s[c*DW +: DW]),
            .out_valid (MREQ_VALID_o[c]),
            .out_ready (MREQ_READY_i[c]),
            .out_data  (MREQ_o[c*DW +: DW])
        );
    end

    connect_skid #(.DW(DW)) u_ro_skid (
        .clk       (CLK_i),
        .rst_n     (RSTN_i),
        .srst      (1'b0),
        .in_valid  (ro_valid_s),
        .in_ready  (ro_ready_s),
        .in_data   (ro_data_s),
        .out_valid (RO_VALID_o),
        .out_ready (RO_READY_i),
        .out_data  (RO_o)
    );

    // A buffer holding data counts as pending traffic for the drain
    assign skid_busy_s = (|MREQ_VALID_o) | RO_VALID_o;
`else
    assign MREQ_VALID_o = mreq_valid_s;
    assign MREQ_o       = mreq_data_s;
    assign mreq_ready_s = MREQ_READY_i;
    assign RO_VALID_o   = ro_valid_s;
    assign RO_o         = ro_data_s;
    assign ro_ready_s   = RO_READY_i;
    assign skid_busy_s  = 1'b0;
`endif

    // Bursts open on the engine-side AR/AW handshake and close on last R / B
    assign rd_inc_s = REQ_VALID_i[CH_AR] & REQ_READY_o[CH_AR];
    assign rd_dec_s = RO_VALID_o & RO_READY_i & RO_o[RLAST_BIT];
    assign wr_inc_s = REQ_VALID_i[CH_AW] & REQ_READY_o[CH_AW];
    assign wr_dec_s = BO_VALID_o & BO_READY_i;

    assign underflow_s = (rd_dec_s & ~rd_inc_s & (rd_cnt_r == {CW{1'b0}})) |
                         (wr_dec_s & ~wr_inc_s & (wr_cnt_r == {CW{1'b0}}));

    assign drain_idle_s = (rd_cnt_r == {CW{1'b0}}) && (wr_cnt_r == {CW{1'b0}}) &&
                          !(|mreq_valid_s) && !(|EREQ_VALID_o) && !skid_busy_s;

    // Outstanding-burst counters and sticky underflow flag
    always_ff @(posedge CLK_i or negedge RSTN_i) begin
        if (!RSTN_i) begin
            rd_cnt_r <= {CW{1'b0}};
            wr_cnt_r <= {CW{1'b0}};
            err_r    <= 1'b0;
        end else begin
            rd_cnt_r <= cnt_next(rd_cnt_r, rd_inc_s, rd_dec_s);
            wr_cnt_r <= cnt_next(wr_cnt_r, wr_inc_s, wr_dec_s);
            if (underflow_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // Mode-switch FSM; ENABLE_o flips and BUSY_o falls on the drain-complete edge
    always_ff @(posedge CLK_i or negedge RSTN_i) begin
        if (!RSTN_i) begin
            state_r  <= BYP;
            enable_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                BYP: begin
                    if (ENABLE_REQ_i) begin
                        state_r <= DRN_C;
                        busy_r  <= 1'b1;
                    end
                end
                DRN_C: begin
                    if (!ENABLE_REQ_i) begin
                        state_r <= BYP;
                        busy_r  <= 1'b0;
                    end else if (drain_idle_s) begin
                        state_r  <= CMP;
                        busy_r   <= 1'b0;
                        enable_r <= 1'b1;
                    end
                end
                CMP: begin
                    if (!ENABLE_REQ_i) begin
                        state_r <= DRN_B;
                        busy_r  <= 1'b1;
                    end
                end
                DRN_B: begin
                    if (ENABLE_REQ_i) begin
                        state_r <= CMP;
                        busy_r  <= 1'b0;
                    end else if (drain_idle_s) begin
                        state_r  <= BYP;
                        busy_r   <= 1'b0;
                        enable_r <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= BYP;
                    busy_r   <= 1'b0;
                    enable_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_connect_switch.sv
// -----------------------------------------------------------------------------
// tb_connect_switch
// Self-checking bench for connect_switch (default build). A behavioural model
// tracks the mode, a drain flag and the outstanding read/write burst counts as
// plain integers and predicts every routed output once per cycle.
// -----------------------------------------------------------------------------
module tb_connect_switch;

    localparam int DW   = 32;
    localparam int MAXO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_req;
    logic        enable, busy, err;
    logic [2:0]  req_valid, req_ready, ereq_valid, ereq_ready;
    logic [2:0]  creq_valid, creq_ready, mreq_valid, mreq_ready;
    logic [95:0] req, ereq, creq, mreq;
    logic        r_valid, r_ready, er_valid, er_ready, cr_valid, cr_ready;
    logic        ro_valid, ro_ready, b_valid, b_ready, bo_valid, bo_ready;
    logic [31:0] r, er, cr, ro, b, bo;

    int checks = 0;
    int errors = 0;

    // model state and its next-cycle values
    bit m_en, m_drain, m_err, n_en, n_drain, n_err;
    int m_rd, m_wr, n_rd, n_wr;

    always #5 clk = ~clk;

    connect_switch #(.DW(DW), .MAX_OUTSTD(MAXO), .RLAST_BIT(0)) dut (
        .CLK_i(clk), .RSTN_i(rst_n), .ENABLE_REQ_i(enable_req),
        .ENABLE_o(enable), .BUSY_o(busy), .ERR_o(err),
        .REQ_VALID_i(req_valid), .REQ_READY_o(req_ready), .REQ_i(req),
        .EREQ_VALID_o(ereq_valid), .EREQ_READY_i(ereq_ready), .EREQ_o(ereq),
        .CREQ_VALID_i(creq_valid), .CREQ_READY_o(creq_ready), .CREQ_i(creq),
        .MREQ_VALID_o(mreq_valid), .MREQ_READY_i(mreq_ready), .MREQ_o(mreq),
        .R_VALID_i(r_valid), .R_READY_o(r_ready), .R_i(r),
        .ER_VALID_o(er_valid), .ER_READY_i(er_ready), .ER_o(er),
        .CR_VALID_i(cr_valid), .CR_READY_o(cr_ready), .CR_i(cr),
        .RO_VALID_o(ro_valid), .RO_READY_i(ro_ready), .RO_o(ro),
        .B_VALID_i(b_valid), .B_READY_o(b_ready), .B_i(b),
        .BO_VALID_o(bo_valid), .BO_READY_i(bo_ready), .BO_o(bo)
    );

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        req_valid = 3'b000; creq_valid = 3'b000;
        r_valid = 1'b0; cr_valid = 1'b0; b_valid = 1'b0;
        req = 96'd0; creq = 96'd0; r = 32'd0; cr = 32'd0; b = 32'd0;
        ereq_ready = 3'b111; mreq_ready = 3'b111;
        er_ready = 1'b1; ro_ready = 1'b1; bo_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable_req = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("rst_enable", 96'(enable), 96'd0);
        check("rst_busy", 96'(busy), 96'd0);
        check("rst_err", 96'(err), 96'd0);
        check("rst_mreq_valid", 96'(mreq_valid), 96'd0);
        check("rst_ereq_valid", 96'(ereq_valid), 96'd0);
        check("rst_ro_valid", 96'(ro_valid), 96'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_en = 1'b0; m_drain = 1'b0; m_err = 1'b0; m_rd = 0; m_wr = 0;
    endtask

    // Predict and compare this cycle's outputs, then work out the model's next state
    task automatic sample();
        logic [2:0]  ok, e_rdy, e_mv, e_ev;
        logic [95:0] e_md;
        logic        e_rov, e_rr, e_crr, e_erv, idle;
        logic [31:0] e_rod;
        int ar, aw, rl, bh;
        @(negedge clk);
        ok[0] = !m_drain && (m_rd < MAXO);
        ok[1] = !m_drain && (m_wr < MAXO);
        ok[2] = !m_drain;
        if (m_en) begin
            e_rdy = ereq_ready & ok; e_ev = req_valid & ok;
            e_mv = creq_valid; e_md = creq;
            e_rov = cr_valid; e_rod = cr; e_rr = er_ready; e_crr = ro_ready; e_erv = r_valid;
        end else begin
            e_rdy = mreq_ready & ok; e_ev = 3'b000;
            e_mv = req_valid & ok; e_md = req;
            e_rov = r_valid; e_rod = r; e_rr = ro_ready; e_crr = 1'b0; e_erv = 1'b0;
        end
        check("enable", 96'(enable), 96'(m_en));
        check("busy", 96'(busy), 96'(m_drain));
        check("err", 96'(err), 96'(m_err));
        check("req_ready", 96'(req_ready), 96'(e_rdy));
        check("mreq_valid", 96'(mreq_valid), 96'(e_mv));
        check("mreq_data", mreq, e_md);
        check("ereq_valid", 96'(ereq_valid), 96'(e_ev));
        check("er_valid", 96'(er_valid), 96'(e_erv));
        check("ro_valid", 96'(ro_valid), 96'(e_rov));
        check("ro_data", 96'(ro), 96'(e_rod));
        check("r_ready", 96'(r_ready), 96'(e_rr));
        check("cr_ready", 96'(cr_ready), 96'(e_crr));
        check("bo_valid", 96'(bo_valid), 96'(b_valid));
        ar = int'(req_valid[0] & e_rdy[0]);
        aw = int'(req_valid[1] & e_rdy[1]);
        rl = int'(e_rov & ro_ready & e_rod[0]);
        bh = int'(b_valid & bo_ready);
        idle = (m_rd == 0) && (m_wr == 0) && (e_mv == 3'b000) && (e_ev == 3'b000);
        n_err = m_err;
        n_rd = m_rd + ar - rl;
        if (n_rd < 0) begin n_rd = 0; n_err = 1'b1; end
        n_wr = m_wr + aw - bh;
        if (n_wr < 0) begin n_wr = 0; n_err = 1'b1; end
        n_en = m_en; n_drain = m_drain;
        if (!m_drain) begin
            if (enable_req != m_en) n_drain = 1'b1;
        end else if (enable_req == m_en) begin
            n_drain = 1'b0;
        end else if (idle) begin
            n_drain = 1'b0; n_en = !m_en;
        end
    endtask

    task automatic advance();
        @(posedge clk); #1;
        m_en = n_en; m_drain = n_drain; m_err = n_err; m_rd = n_rd; m_wr = n_wr;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        logic [31:0] tmp;
        rst_n = 1'b0;
        do_reset();

        // bypass: AR lands on MREQ the same cycle, nothing on EREQ
        req_valid = 3'b001; req[31:0] = 32'h1234;
        sample();
        check("byp_mreq_ar", 96'(mreq[31:0]), 96'h1234);
        check("byp_ereq_valid", 96'(ereq_valid), 96'd0);
        advance();
        req[31:0] = 32'h5678;
        step();
        idle_inputs();

        // switch with two reads outstanding
        enable_req = 1'b1;
        step();
        req_valid = 3'b111;
        sample();
        check("drn_busy", 96'(busy), 96'd1);
        check("drn_req_ready", 96'(req_ready), 96'd0);
        advance();
        req_valid = 3'b000;
        r_valid = 1'b1; r = 32'h1;
        repeat (2) step();
        idle_inputs();
        sample();
        check("drn_still_byp", 96'(enable), 96'd0);
        advance();
        sample();
        check("cmp_enable", 96'(enable), 96'd1);
        check("cmp_busy", 96'(busy), 96'd0);
        advance();

        // compress path
        req_valid = 3'b010; req[63:32] = 32'hBEEF;
        creq_valid = 3'b001; creq[31:0] = 32'hA5A5;
        cr_valid = 1'b1; cr = 32'hC0DE0;
        sample();
        check("cmp_ereq_valid", 96'(ereq_valid), 96'b010);
        check("cmp_ereq_aw", 96'(ereq[63:32]), 96'hBEEF);
        check("cmp_mreq_creq", 96'(mreq[31:0]), 96'hA5A5);
        check("cmp_ro_cr", 96'(ro), 96'hC0DE0);
        advance();
        idle_inputs();
        b_valid = 1'b1;
        step();
        idle_inputs();
        enable_req = 1'b0;
        repeat (2) step();
        sample();
        check("back_byp", 96'(enable), 96'd0);
        advance();

        // abort a drain towards compress
        req_valid = 3'b001;
        step();
        req_valid = 3'b000;
        enable_req = 1'b1;
        step();
        enable_req = 1'b0;
        sample();
        check("abort_busy_in_drn", 96'(busy), 96'd1);
        advance();
        sample();
        check("abort_busy", 96'(busy), 96'd0);
        check("abort_enable", 96'(enable), 96'd0);
        advance();
        r_valid = 1'b1; r = 32'h1;
        step();
        idle_inputs();

        // spurious B -> sticky underflow until reset
        b_valid = 1'b1;
        step();
        idle_inputs();
        repeat (3) step();
        check("err_sticky", 96'(err), 96'd1);
        do_reset();

        // throttle at MAX_OUTSTD writes
        req_valid = 3'b010;
        repeat (MAXO) step();
        b_valid = 1'b1;
        sample();
        check("thr_blocked", 96'(req_ready[1]), 96'd0);
        advance();
        b_valid = 1'b0; req_valid = 3'b000;
        sample();
        check("thr_released", 96'(req_ready[1]), 96'd1);
        advance();

        // reset with bursts in flight drops the counts
        do_reset();
        sample();
        check("rst_cnt_clear", 96'(req_ready), 96'b111);
        advance();

        // randomized traffic with occasional mode requests
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(15) == 0) enable_req = ~enable_req;
            req_valid  = 3'($urandom);
            req        = {$urandom, $urandom, $urandom};
            ereq_ready = 3'($urandom);
            mreq_ready = 3'($urandom);
            creq_valid = 3'($urandom);
            creq       = {$urandom, $urandom, $urandom};
            r_valid    = 1'($urandom);
            tmp        = $urandom;
            tmp[0]     = (m_rd > 0) ? 1'($urandom) : 1'b0;
            r          = tmp;
            cr_valid   = 1'($urandom);
            tmp        = $urandom;
            tmp[0]     = (m_rd > 0) ? 1'($urandom) : 1'b0;
            cr         = tmp;
            er_ready   = 1'($urandom);
            ro_ready   = 1'($urandom);
            b_valid    = (m_wr > 0) ? 1'($urandom) : 1'b0;
            b          = $urandom;
            bo_ready   = 1'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/connect_switch.md
Name: connect_switch

Overview:
- Registered, handshake-aware successor of the AIDC/XHB channel connect block.
- Steers CNN-engine AR/AW/W requests either straight to XHB (bypass) or through AIDC (compress), and steers the XHB R channel the matching way.
- Mode changes are safe: a drain FSM blocks new requests and waits until every outstanding read and write has completed before flipping the path.
- The B channel passes through, but is counted.

Parameters:
- DW, 32, payload width per channel.
- MAX_OUTSTD, 16, maximum outstanding bursts per direction; counter width is $clog2(MAX_OUTSTD+1).
- RLAST_BIT, 0, bit index of the burst-last flag inside the R payload.

Ports:
- CLK_i  in  1  clock
- RSTN_i  in  1  reset; asynchronous, active-low
- ENABLE_REQ_i  in  1  requested mode; 1 = compress
- ENABLE_o  out  1  effective mode
- BUSY_o  out  1  drain in progress
- ERR_o  out  1  sticky counter underflow
- REQ_VALID_i / REQ_READY_o / REQ_i  in/out/in  3/3/3*DW  engine requests; index 0=AR, 1=AW, 2=W; channel c occupies [c*DW +: DW]
- EREQ_VALID_o / EREQ_READY_i / EREQ_o  out/in/out  3/3/3*DW  requests to AIDC
- CREQ_VALID_i / CREQ_READY_o / CREQ_i  in/out/in  3/3/3*DW  compressed requests from AIDC
- MREQ_VALID_o / MREQ_READY_i / MREQ_o  out/in/out  3/3/3*DW  requests to XHB
- R_VALID_i / R_READY_o / R_i  in/out/in  1/1/DW  R from XHB
- ER_VALID_o / ER_READY_i / ER_o  out/in/out  1/1/DW  R to AIDC
- CR_VALID_i / CR_READY_o / CR_i  in/out/in  1/1/DW  decompressed R from AIDC
- RO_VALID_o / RO_READY_i / RO_o  out/in/out  1/1/DW  R to engine
- B_VALID_i / B_READY_o / B_i  in/out/in  1/1/DW  B from XHB
- BO_VALID_o / BO_READY_i / BO_o  out/in/out  1/1/DW  B to engine

Behaviour:
- Reset values:
  - State BYP.
  - ENABLE_o=0, BUSY_o=0, ERR_o=0.
  - Both counters 0.
  - All VALID outputs 0.
- BYP (ENABLE_o=0):
  - REQ is wired to MREQ, and R to RO.
  - EREQ/ER valid forced 0; CREQ/CR ready forced 0.
- CMP (ENABLE_o=1):
  - REQ to EREQ, CREQ to MREQ.
  - R to ER, CR to RO.
  - Unused valids are forced 0 and unused readies forced 0.
- B: BO=B combinationally, in every state.
- Counters:
  - RD_CNT increments on an engine AR handshake and decrements on an RO handshake with RO_o[RLAST_BIT]=1.
  - WR_CNT increments on an AW handshake and decrements on a BO handshake.
  - A simultaneous increment and decrement leaves the count unchanged.
- Throttle: when a counter is at MAX_OUTSTD, REQ_READY_o for the matching AR/AW channel is 0.
- Underflow: a decrement while the counter is 0 holds the counter at 0 and sets ERR_o until reset.
- FSM states: BYP, DRN_C, CMP, DRN_B.
  - BYP goes to DRN_C when ENABLE_REQ_i=1.
  - CMP goes to DRN_B when ENABLE_REQ_i=0.
  - In DRN_*: BUSY_o=1 and REQ_READY_o=3'b000. Downstream, R and B continue on the current path.
  - DRN_C goes to CMP, and DRN_B goes to BYP, on the first cycle where RD_CNT==0, WR_CNT==0 and no MREQ/EREQ valid is pending. ENABLE_o toggles on that same edge and BUSY_o falls.
  - Abort: if ENABLE_REQ_i reverts during a drain, return to the originating steady state next cycle with ENABLE_o unchanged.
- Latency: request and R paths are zero-latency combinational unless CONNECT_OREG_EN is defined. Mode switch costs at least 1 cycle.
- Reset mid-burst: everything returns to reset values immediately; in-flight bursts are discarded.

Optional Feature:
- Macro: CONNECT_OREG_EN.
- Defined: each MREQ channel and RO get a 2-entry skid buffer.
  - Adds 1 cycle latency at full throughput.
  - READY becomes registered.
  - The drain condition also requires all skid buffers to be empty.
- Undefined: purely combinational paths, as described above.

Decomposition:
- Package connect_pkg holds:
  - Channel index constants CH_AR=0, CH_AW=1, CH_W=2, NREQ=3.
  - FSM state enum sw_state_t {BYP, DRN_C, CMP, DRN_B}.
- Sub-module connect_skid: parametrised DW, a 2-entry valid/ready skid buffer, instantiated only under CONNECT_OREG_EN.

Test Plan:
- Bypass: with ENABLE_REQ_i=0, send AR payload 0x1234 -> MREQ_o[31:0]=0x1234 in the same cycle; EREQ_VALID_o stays 0.
- Switch with traffic: 2 ARs outstanding, then set ENABLE_REQ_i=1 -> BUSY_o=1 and REQ_READY_o=0 until the 2nd last-R handshake; ENABLE_o=1 on the next edge.
- Compress path: in CMP, an AW from the engine appears on EREQ; CREQ payload 0xA5A5 reaches MREQ; CR data reaches RO_o.
- Throttle: issue 16 AWs with no B -> REQ_READY_o[1]=0; one B handshake -> REQ_READY_o[1]=1 on the next cycle.
- Abort and underflow:
  - Drop ENABLE_REQ_i during DRN_C -> back in BYP next cycle, ENABLE_o=0.
  - Inject a spurious B with WR_CNT=0 -> ERR_o=1 and held until RSTN_i low.
